fetch_sequencer: RTL and testbench

Instruction-fetch controller that sequences the program counter. Reads the opcode and 0–2 operand words from program memory through a request/acknowledge handshake, then presents the assembled instruction to the execute stage. After execute completes, it issues the one-cycle `pc_load` pulse with the opcode held stable, so the program counter advances by the instruction size. It sits between the program counter, program memory and the execute unit.

---
 rtl/fetch_pkg.sv | 47 ++++
 rtl/fetch_sequencer.sv | 135 +++++++++++++
 tb/tb_fetch_sequencer.sv | 273 +++++++++++++++++++++++++++
 3 files changed

// File: rtl/fetch_pkg.sv
// Shared fetch-stage types and the instruction-size decode, also used by the program counter.
// FETCH_SEQ_HALT_EN makes HLT (0xF4) a 1-word opcode and adds the HALT state.
package fetch_pkg;

  localparam int unsigned OpWidth = 8;

  localparam logic [OpWidth-1:0] Op78  = 8'h78;
  localparam logic [OpWidth-1:0] Op80  = 8'h80;
  localparam logic [OpWidth-1:0] Op81  = 8'h81;
  localparam logic [OpWidth-1:0] Op82  = 8'h82;
  localparam logic [OpWidth-1:0] Op83  = 8'h83;
  localparam logic [OpWidth-1:0] Op84  = 8'h84;
  localparam logic [OpWidth-1:0] Op85  = 8'h85;
  localparam logic [OpWidth-1:0] Op86  = 8'h86;
  localparam logic [OpWidth-1:0] Op87  = 8'h87;
  localparam logic [OpWidth-1:0] OpHlt = 8'hF4;

  localparam logic [1:0] SizeOne   = 2'd1;
  localparam logic [1:0] SizeTwo   = 2'd2;
  localparam logic [1:0] SizeThree = 2'd3;

  typedef enum logic [2:0] {
    StFetchOp,
    StFetch1,
    StFetch2,
    StExec,
    StAdvance
`ifdef FETCH_SEQ_HALT_EN
    , StHalt
`endif
  } state_e;

  // Number of program words (opcode plus operands) occupied by an instruction.
  function automatic logic [1:0] instr_size(input logic [OpWidth-1:0] op);
    logic [1:0] size;
    case (op)
      Op83:                                   size = SizeOne;
      Op78, Op80, Op81, Op82, Op84, Op85, Op87: size = SizeTwo;
`ifdef FETCH_SEQ_HALT_EN
      OpHlt:                                  size = SizeOne;
`endif
      default:                                size = SizeThree;
    endcase
    return size;
  endfunction

endpackage

// File: rtl/fetch_sequencer.sv
// Instruction-fetch sequencer: reads opcode plus 0-2 operands, presents them to execute, then
// pulses pc_load. Define FETCH_SEQ_HALT_EN to enable the HLT opcode and the HALT state.
module fetch_sequencer
  import fetch_pkg::*;
#(
  parameter int unsigned ADDR_W = 6,
  parameter int unsigned WORD_W = 8
) (
  input  logic              clock,
  input  logic              reset,
  input  logic [ADDR_W-1:0] pc,
  output logic              pc_load,
  output logic [WORD_W-1:0] opcode,
  output logic              mem_rd_req,
  output logic [ADDR_W-1:0] mem_rd_addr,
  input  logic              mem_rd_ack,
  input  logic [WORD_W-1:0] mem_rd_data,
  output logic [WORD_W-1:0] operand1,
  output logic [WORD_W-1:0] operand2,
  output logic              instr_valid,
  input  logic              exec_done,
  output logic              halted
);

  state_e            state_q, state_d;
  logic [WORD_W-1:0] opcode_q, opcode_d;
  logic [WORD_W-1:0] operand1_q, operand1_d;
  logic [WORD_W-1:0] operand2_q, operand2_d;
  logic              instr_valid_q;
  logic              pc_load_q;

  always_comb begin
    state_d    = state_q;
    opcode_d   = opcode_q;
    operand1_d = operand1_q;
    operand2_d = operand2_q;
    case (state_q)
      StFetchOp: begin
        if (mem_rd_ack) begin
          opcode_d   = mem_rd_data;
          operand1_d = '0;
          operand2_d = '0;
          state_d    = (instr_size(mem_rd_data[OpWidth-1:0]) == SizeOne) ? StExec : StFetch1;
        end
      end
      StFetch1: begin
        if (mem_rd_ack) begin
          operand1_d = mem_rd_data;
          state_d    = (instr_size(opcode_q[OpWidth-1:0]) == SizeTwo) ? StExec : StFetch2;
        end
      end
      StFetch2: begin
        if (mem_rd_ack) begin
          operand2_d = mem_rd_data;
          state_d    = StExec;
        end
      end
      StExec: begin
        if (exec_done) state_d = StAdvance;
      end
      StAdvance: begin
`ifdef FETCH_SEQ_HALT_EN
        state_d = (opcode_q[OpWidth-1:0] == OpHlt) ? StHalt : StFetchOp;
`else
        state_d = StFetchOp;
`endif
      end
`ifdef FETCH_SEQ_HALT_EN
      StHalt: state_d = StHalt;
`endif
      default: state_d = StFetchOp;
    endcase
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q       <= StFetchOp;
      opcode_q      <= '0;
      operand1_q    <= '0;
      operand2_q    <= '0;
      instr_valid_q <= 1'b0;
      pc_load_q     <= 1'b0;
    end else begin
      state_q       <= state_d;
      opcode_q      <= opcode_d;
      operand1_q    <= operand1_d;
      operand2_q    <= operand2_d;
      instr_valid_q <= (state_d == StExec);
      pc_load_q     <= (state_d == StAdvance);
    end
  end

`ifdef FETCH_SEQ_HALT_EN
  logic halted_q;

  always_ff @(posedge clock or posedge reset) begin
    if (reset) halted_q <= 1'b0;
    else       halted_q <= (state_d == StHalt);
  end

  assign halted = halted_q;
`else
  assign halted = 1'b0;
`endif

  // Gated by reset so an in-flight read is dropped without waiting for a clock edge.
  always_comb begin
    mem_rd_req  = 1'b0;
    mem_rd_addr = '0;
    if (!reset) begin
      case (state_q)
        StFetchOp: begin
          mem_rd_req  = 1'b1;
          mem_rd_addr = pc;
        end
        StFetch1: begin
          mem_rd_req  = 1'b1;
          mem_rd_addr = pc + ADDR_W'(1);
        end
        StFetch2: begin
          mem_rd_req  = 1'b1;
          mem_rd_addr = pc + ADDR_W'(2);
        end
        default: ;
      endcase
    end
  end

  assign opcode      = opcode_q;
  assign operand1    = operand1_q;
  assign operand2    = operand2_q;
  assign instr_valid = instr_valid_q;
  assign pc_load     = pc_load_q;

endmodule

// File: tb/tb_fetch_sequencer.sv
// Scoreboard bench for fetch_sequencer: memory responder with wait states, read-address and
// instruction queues checked by a monitor, directed tests for wrap, reset and (optionally) HLT.
module tb_fetch_sequencer;

  logic       clock;
  logic       reset;
  logic [5:0] pc;
  logic       pc_load;
  logic [7:0] opcode;
  logic       mem_rd_req;
  logic [5:0] mem_rd_addr;
  logic       mem_rd_ack;
  logic [7:0] mem_rd_data;
  logic [7:0] operand1;
  logic [7:0] operand2;
  logic       instr_valid;
  logic       exec_done;
  logic       halted;

  fetch_sequencer #(
    .ADDR_W(6),
    .WORD_W(8)
  ) dut (
    .clock      (clock),
    .reset      (reset),
    .pc         (pc),
    .pc_load    (pc_load),
    .opcode     (opcode),
    .mem_rd_req (mem_rd_req),
    .mem_rd_addr(mem_rd_addr),
    .mem_rd_ack (mem_rd_ack),
    .mem_rd_data(mem_rd_data),
    .operand1   (operand1),
    .operand2   (operand2),
    .instr_valid(instr_valid),
    .exec_done  (exec_done),
    .halted     (halted)
  );

  logic [7:0]  mem [64];
  logic [5:0]  exp_addr [$];
  logic [23:0] exp_instr [$];
  int          wait_cfg;
  int          wait_cnt;
  logic        spurious;
  int          n_checks = 0;
  int          n_errors = 0;

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: observed 0x%0h, expected 0x%0h", tag, obs, exp);
    end
  endtask

  function automatic int tb_size(input logic [7:0] op);
    case (op)
      8'h83: return 1;
      8'h78, 8'h80, 8'h81, 8'h82, 8'h84, 8'h85, 8'h87: return 2;
`ifdef FETCH_SEQ_HALT_EN
      8'hF4: return 1;
`endif
      default: return 3;
    endcase
  endfunction

  // Memory model: decides ack just after each rising edge, so it is stable for the next one.
  initial begin : responder
    mem_rd_ack  = 1'b0;
    mem_rd_data = 8'h00;
    wait_cnt    = 0;
    forever begin
      @(posedge clock);
      #1;
      if (reset) begin
        mem_rd_ack  = 1'b0;
        mem_rd_data = 8'h00;
        wait_cnt    = 0;
      end else if (mem_rd_req) begin
        if (wait_cnt >= wait_cfg) begin
          mem_rd_ack  = 1'b1;
          mem_rd_data = mem[mem_rd_addr];
          wait_cnt    = 0;
        end else begin
          mem_rd_ack  = 1'b0;
          mem_rd_data = 8'h00;
          wait_cnt++;
        end
      end else begin
        mem_rd_ack  = spurious;
        mem_rd_data = spurious ? 8'hA5 : 8'h00;
        wait_cnt    = 0;
      end
    end
  end

  initial begin : monitor
    logic        prev_req, prev_ack, prev_valid, prev_load;
    logic [5:0]  prev_addr, ea;
    logic [23:0] ei;
    prev_req = 1'b0; prev_ack = 1'b0; prev_valid = 1'b0; prev_load = 1'b0; prev_addr = '0;
    forever begin
      @(negedge clock);
      if (reset) begin
        prev_req = 1'b0; prev_ack = 1'b0; prev_valid = 1'b0; prev_load = 1'b0;
      end else begin
        if (mem_rd_req && mem_rd_ack) begin
          check_eq("rd_expected", 32'(exp_addr.size() != 0), 32'd1);
          if (exp_addr.size() != 0) begin
            ea = exp_addr.pop_front();
            check_eq("rd_addr", 32'(mem_rd_addr), 32'(ea));
          end
        end
        if (mem_rd_req && prev_req && !prev_ack)
          check_eq("addr_hold", 32'(mem_rd_addr), 32'(prev_addr));
        if (instr_valid && !prev_valid) begin
          check_eq("instr_expected", 32'(exp_instr.size() != 0), 32'd1);
          if (exp_instr.size() != 0) begin
            ei = exp_instr.pop_front();
            check_eq("instr_fields", {8'h00, opcode, operand1, operand2}, {8'h00, ei});
          end
        end
        if (pc_load) check_eq("pc_load_pulse", 32'(prev_load), 32'd0);
        prev_req   = mem_rd_req;
        prev_ack   = mem_rd_ack;
        prev_addr  = mem_rd_addr;
        prev_valid = instr_valid;
        prev_load  = pc_load;
      end
    end
  end

  // Runs one instruction from pc=p; returns at the falling edge inside the ADVANCE cycle.
  task automatic run_instr(input logic [5:0] p, input int w, input int ed);
    logic [7:0] op, o1, o2;
    logic [5:0] a1, a2;
    int s, lat, bad;
    pc       = p;
    wait_cfg = w;
    a1 = p + 6'd1;
    a2 = p + 6'd2;
    op = mem[p];
    s  = tb_size(op);
    o1 = (s > 1) ? mem[a1] : 8'h00;
    o2 = (s > 2) ? mem[a2] : 8'h00;
    exp_addr.push_back(p);
    if (s > 1) exp_addr.push_back(a1);
    if (s > 2) exp_addr.push_back(a2);
    exp_instr.push_back({op, o1, o2});
    lat = 0;
    do begin
      @(negedge clock);
      lat++;
    end while (!instr_valid && lat < 100);
    check_eq("fetch_latency", 32'(lat), 32'(s * (w + 1) + 1));
    bad = 0;
    repeat (ed) begin
      @(negedge clock);
      if (!instr_valid || pc_load) bad++;
    end
    check_eq("exec_hold", 32'(bad), 32'd0);
    exec_done = 1'b1;
    @(negedge clock);
    exec_done = 1'b0;
    check_eq("pc_load", 32'(pc_load), 32'd1);
    check_eq("valid_drop", 32'(instr_valid), 32'd0);
    check_eq("load_instr", {8'h00, opcode, operand1, operand2}, {8'h00, op, o1, o2});
    check_eq("reads_done", 32'(exp_addr.size()), 32'd0);
  endtask

  initial begin : watchdog
    #500000;
    $display("FAIL watchdog: run incomplete, expected summary before time limit");
    $fatal(1, "watchdog expired");
  end

  initial begin : main
    logic [7:0] op;
    logic [5:0] rp;
    int lat, bad;
    reset     = 1'b1;
    pc        = 6'd0;
    exec_done = 1'b0;
    wait_cfg  = 0;
    spurious  = 1'b0;
    for (int i = 0; i < 64; i++) mem[i] = 8'($urandom);
    mem[0]  = 8'h83;
    mem[5]  = 8'h80; mem[6]  = 8'h3C;
    mem[62] = 8'h10; mem[63] = 8'h55;

    repeat (3) @(negedge clock);
    check_eq("rst_req", 32'(mem_rd_req), 32'd0);
    check_eq("rst_addr", 32'(mem_rd_addr), 32'd0);
    check_eq("rst_regs", {8'h00, opcode, operand1, operand2}, 32'd0);
    check_eq("rst_flags", {29'd0, instr_valid, pc_load, halted}, 32'd0);
    #1 reset = 1'b0;

    run_instr(6'd0, 0, 1);   // 1-word
    run_instr(6'd5, 0, 0);   // 2-word
    run_instr(6'd62, 0, 0);  // 3-word, address wraps to 0

    // Wait states, long execute, and acks arriving outside fetch states.
    mem[20] = 8'h10;
    spurious = 1'b1;
    run_instr(6'd20, 3, 10);
    spurious = 1'b0;
    mem[30] = 8'h87;
    run_instr(6'd30, 2, 0);

    for (int i = 0; i < 8; i++) begin
      case ($urandom_range(7))
        0: op = 8'h83;
        1: op = 8'h78;
        2: op = 8'h84;
        3: op = 8'h86;
        4: op = 8'h10;
        5: op = 8'h85;
        6: op = 8'h81;
        default: op = 8'hF0;
      endcase
      rp = 6'($urandom_range(63));
      mem[rp] = op;
      run_instr(rp, $urandom_range(2), $urandom_range(3));
    end

    // Reset while the first operand read is pending.
    pc = 6'd10;
    mem[10] = 8'h10;
    wait_cfg = 3;
    exp_addr.push_back(6'd10);
    lat = 0;
    do begin
      @(negedge clock);
      lat++;
    end while (mem_rd_addr != 6'd11 && lat < 50);
    check_eq("reach_fetch1", 32'(mem_rd_addr), 32'd11);
    #1 reset = 1'b1;
    #1;
    check_eq("midrst_req", 32'(mem_rd_req), 32'd0);
    check_eq("midrst_addr", 32'(mem_rd_addr), 32'd0);
    check_eq("midrst_regs", {8'h00, opcode, operand1, operand2}, 32'd0);
    check_eq("midrst_flags", {29'd0, instr_valid, pc_load, halted}, 32'd0);
    check_eq("midrst_reads", 32'(exp_addr.size()), 32'd0);
    exp_addr.delete();
    exp_instr.delete();
    repeat (2) @(negedge clock);
    #1 reset = 1'b0;
    mem[10] = 8'h82;
    run_instr(6'd10, 0, 0);

    mem[40] = 8'hF4;
    run_instr(6'd40, 0, 0);
`ifdef FETCH_SEQ_HALT_EN
    bad = 0;
    repeat (20) begin
      @(negedge clock);
      if (mem_rd_req || pc_load || !halted) bad++;
    end
    check_eq("halt_idle", 32'(bad), 32'd0);
    check_eq("halted", 32'(halted), 32'd1);
`else
    check_eq("halted_tied", 32'(halted), 32'd0);
`endif

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
